keypad_scan: RTL and testbench

Scans a 4x4 active-low key matrix. It drives one row low at a time, samples the columns, and debounces the result. Each accepted key press becomes a 4-bit code held in a valid/ack output register. It is the input-side counterpart of the display scanners: the row-drive/column-sense reader for the front-panel keypad, feeding mode and pedestrian requests to the traffic controller.

---
 rtl/keypad_scan.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_keypad_scan.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low key matrix scanner with debounce and a valid/ack event register.
// Optional auto-repeat is compiled in when the macro KEYPAD_REPEAT_EN is defined.
module keypad_scan #(
  parameter int SCAN_DIV     = 1024,
  parameter int DEBOUNCE     = 3,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  input  logic       key_ack,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overflow
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DEB      = 4'(DEBOUNCE);

  if ((SCAN_DIV < 4) || (SCAN_DIV > 65535) || (DEBOUNCE < 1) || (DEBOUNCE > 15) ||
      (REPEAT_DELAY < 1) || (REPEAT_DELAY > 65535) || (REPEAT_RATE < 1) || (REPEAT_RATE > 65535))
  begin : g_bad_cfg
    $error("keypad_scan: parameter out of legal range");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  // Number of low columns, saturated at 2 (two or more means MULTI).
  function automatic logic [1:0] f_count_low(input logic [3:0] v);
    logic [2:0] n;
    n = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    return (n > 3'd1) ? 2'd2 : n[1:0];
  endfunction

  function automatic logic [1:0] f_low_index(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

  function automatic logic [1:0] f_sat_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = 3'(a) + 3'(b);
    return (s > 3'd1) ? 2'd2 : s[1:0];
  endfunction

  logic [3:0]  r_col_s1, r_col_s2;
  logic [15:0] r_div;
  logic [1:0]  r_row;
  logic [3:0]  r_row_out;
  logic [1:0]  r_acc_n;
  logic [3:0]  r_acc_code;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_cand, w_cand_nxt;
  logic [3:0]  r_key_code;
  logic        r_key_valid, r_key_down, r_overflow;

  logic        w_dwell_end, w_frame_end;
  logic [1:0]  w_row_nxt;
  logic [3:0]  w_col_low;
  logic [1:0]  w_row_n, w_row_idx, w_tot;
  logic [3:0]  w_code;
  logic        w_none, w_single, w_match;
  logic [3:0]  w_cnt_inc;
  logic        w_emit;
  logic [3:0]  w_emit_code;
  logic        w_rep_hit;

  assign w_dwell_end = (r_div == DIV_LAST);
  assign w_frame_end = w_dwell_end && (r_row == 2'd3);
  assign w_row_nxt   = r_row + 2'd1;
  assign w_col_low   = ~r_col_s2;
  assign w_row_n     = f_count_low(w_col_low);
  assign w_row_idx   = f_low_index(w_col_low);
  assign w_tot       = f_sat_add(r_acc_n, w_row_n);
  assign w_code      = (w_row_n == 2'd1) ? {r_row, w_row_idx} : r_acc_code;
  assign w_none      = (w_tot == 2'd0);
  assign w_single    = (w_tot == 2'd1);
  assign w_match     = w_single && (w_code == r_cand);
  assign w_cnt_inc   = r_cnt + 4'd1;

  // Two-flop synchronizer for the asynchronous column inputs (idle = all high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= col_in;
      r_col_s2 <= r_col_s1;
    end
  end

  // Row dwell divider, row counter and registered row drive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div     <= 16'd0;
      r_row     <= 2'd0;
      r_row_out <= 4'b1110;
    end else if (w_dwell_end) begin
      r_div     <= 16'd0;
      r_row     <= w_row_nxt;
      r_row_out <= ~(4'b0001 << w_row_nxt);
    end else begin
      r_div     <= r_div + 16'd1;
    end
  end

  // Per-frame accumulation of pressed-key count and the single key's code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_n    <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_frame_end) begin
      r_acc_n    <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_dwell_end) begin
      r_acc_n    <= w_tot;
      r_acc_code <= w_code;
    end else begin
      r_acc_n    <= r_acc_n;
      r_acc_code <= r_acc_code;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [15:0] REP_DLY  = 16'(REPEAT_DELAY);
  localparam logic [15:0] REP_RATE = 16'(REPEAT_RATE);
  logic [15:0] r_rep_cnt;
  logic        r_rep_first;
  logic [15:0] w_rep_target;
  logic [15:0] w_rep_inc;

  assign w_rep_target = r_rep_first ? REP_DLY : REP_RATE;
  assign w_rep_inc    = r_rep_cnt + 16'd1;
  assign w_rep_hit    = (w_rep_inc == w_rep_target);

  // Repeat timer: restarts whenever PRESSED is entered or left, counts held SINGLE(cand) frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rep_cnt   <= 16'd0;
      r_rep_first <= 1'b1;
    end else if ((r_state != S_PRESSED) || (w_state_nxt != S_PRESSED)) begin
      r_rep_cnt   <= 16'd0;
      r_rep_first <= 1'b1;
    end else if (w_frame_end && w_match) begin
      if (w_rep_hit) begin
        r_rep_cnt   <= 16'd0;
        r_rep_first <= 1'b0;
      end else begin
        r_rep_cnt   <= w_rep_inc;
      end
    end else begin
      r_rep_cnt   <= r_rep_cnt;
    end
  end
`else
  assign w_rep_hit = 1'b0;
`endif

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_cand  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // Debounce FSM next state and event emission, evaluated on frame_end only.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_emit      = 1'b0;
    w_emit_code = r_cand;
    if (w_frame_end) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nxt  = w_code;
            w_cnt_nxt   = 4'd1;
            w_emit_code = w_code;
            if (DEB == 4'd1) begin
              w_state_nxt = S_PRESSED;
              w_emit      = 1'b1;
            end else begin
              w_state_nxt = S_DEBOUNCE;
            end
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_DEBOUNCE: begin
          if (w_match) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DEB) begin
              w_state_nxt = S_PRESSED;
              w_emit      = 1'b1;
            end else begin
              w_state_nxt = S_DEBOUNCE;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
          end
        end
        S_PRESSED: begin
          if (w_none) begin
            w_cnt_nxt   = 4'd1;
            w_state_nxt = (DEB == 4'd1) ? S_IDLE : S_RELEASE;
          end else if (w_match && w_rep_hit) begin
            w_emit = 1'b1;
          end else begin
            w_state_nxt = S_PRESSED;
          end
        end
        S_RELEASE: begin
          if (w_none) begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc == DEB) ? S_IDLE : S_RELEASE;
          end else begin
            // Any press while releasing is bounce: back to held, no event.
            w_state_nxt = S_PRESSED;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Event output register: oldest event wins, ack clears valid and overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (w_emit) begin
      if (!r_key_valid) begin
        r_key_code  <= w_emit_code;
        r_key_valid <= 1'b1;
      end else if (key_ack) begin
        r_key_code  <= w_emit_code;
        r_overflow  <= 1'b0;
      end else begin
        r_overflow  <= 1'b1;
      end
    end else if (key_ack && r_key_valid) begin
      r_key_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_key_valid <= r_key_valid;
    end
  end

  // Held-key indicator follows the FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_down <= 1'b0;
    end else begin
      r_key_down <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE);
    end
  end

  assign row_out   = r_row_out;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_down  = r_key_down;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed testbench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3); key matrix modelled from row_out.
module tb_keypad_scan;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_ack = 1'b0;
  logic [3:0]  key_code;
  logic        key_valid, key_down, overflow;
  logic [15:0] keys = 16'h0000;

  int n_checks = 0;
  int n_fail   = 0;
  int ev_cnt   = 0;
  int ev_base  = 0;
  logic prev_valid = 1'b0;

  keypad_scan #(
    .SCAN_DIV(4), .DEBOUNCE(3), .REPEAT_DELAY(32), .REPEAT_RATE(8)
  ) u_dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out), .key_ack(key_ack),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Column sense: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
  end

  // Count rising edges of key_valid.
  always @(posedge clk) begin
    #1;
    if (key_valid && !prev_valid) ev_cnt = ev_cnt + 1;
    prev_valid = key_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic ack_frame();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    repeat (FRAME - 1) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_row_out", 32'(row_out), 32'h0000000E);
    check_eq("rst_code", 32'(key_code), 32'h0);
    check_eq("rst_valid", 32'(key_valid), 32'h0);
    check_eq("rst_down", 32'(key_down), 32'h0);
    check_eq("rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b1;

    // Clean press of row2/col1
    keys = 16'h0000; keys[9] = 1'b1;
    frames(2);
    check_eq("clean_early_valid", 32'(key_valid), 32'h0);
    frames(1);
    check_eq("clean_valid", 32'(key_valid), 32'h1);
    check_eq("clean_code", 32'(key_code), 32'h9);
    check_eq("clean_down", 32'(key_down), 32'h1);
    ev_base = ev_cnt;
    frames(7);
    check_eq("clean_single_event", 32'(ev_cnt - ev_base), 32'h0);
    check_eq("clean_down_held", 32'(key_down), 32'h1);
    keys = 16'h0000;
    frames(2);
    check_eq("release_early_down", 32'(key_down), 32'h1);
    frames(1);
    check_eq("release_down", 32'(key_down), 32'h0);
    ack_frame();
    check_eq("ack_clears_valid", 32'(key_valid), 32'h0);

    // Bounce on row0/col0, then a 3-frame hold
    ev_base = ev_cnt;
    for (int i = 0; i < 6; i++) begin
      keys = 16'h0000; keys[0] = (i % 2 == 0);
      frames(1);
    end
    keys = 16'h0000; keys[0] = 1'b1;
    frames(2);
    check_eq("bounce_no_event", 32'(ev_cnt - ev_base), 32'h0);
    frames(1);
    check_eq("bounce_one_event", 32'(ev_cnt - ev_base), 32'h1);
    check_eq("bounce_code", 32'(key_code), 32'h0);
    keys = 16'h0000;
    frames(3);
    ack_frame();

    // Overflow: 5 accepted, A dropped
    keys = 16'h0000; keys[5] = 1'b1;
    frames(3);
    check_eq("ovf_first_code", 32'(key_code), 32'h5);
    keys = 16'h0000;
    frames(3);
    keys[10] = 1'b1;
    frames(3);
    check_eq("ovf_code_kept", 32'(key_code), 32'h5);
    check_eq("ovf_flag", 32'(overflow), 32'h1);
    check_eq("ovf_valid", 32'(key_valid), 32'h1);
    ack_frame();
    check_eq("ovf_ack_valid", 32'(key_valid), 32'h0);
    check_eq("ovf_ack_flag", 32'(overflow), 32'h0);
    keys = 16'h0000;
    frames(3);

    // Emit and ack in the same cycle
    keys = 16'h0000; keys[12] = 1'b1;
    frames(3);
    keys = 16'h0000;
    frames(3);
    keys[13] = 1'b1;
    frames(3);
    check_eq("same_pre_ovf", 32'(overflow), 32'h1);
    check_eq("same_pre_code", 32'(key_code), 32'hC);
    keys = 16'h0000;
    frames(3);
    keys[3] = 1'b1;
    repeat (3 * FRAME - 1) @(negedge clk);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check_eq("same_code", 32'(key_code), 32'h3);
    check_eq("same_valid", 32'(key_valid), 32'h1);
    check_eq("same_ovf", 32'(overflow), 32'h0);
    ack_frame();
    check_eq("same_ack_valid", 32'(key_valid), 32'h0);
    keys = 16'h0000;
    frames(3);

    // Multi-key press: 1 and 2 together
    ev_base = ev_cnt;
    keys = 16'h0000; keys[1] = 1'b1; keys[2] = 1'b1;
    frames(5);
    check_eq("multi_no_event", 32'(ev_cnt - ev_base), 32'h0);
    check_eq("multi_valid", 32'(key_valid), 32'h0);
    check_eq("multi_down", 32'(key_down), 32'h0);
    keys = 16'h0000;
    frames(1);

    // Reset mid-debounce, with a pending event and mid-scan row
    keys[14] = 1'b1;
    frames(3);
    check_eq("pre_rst_valid", 32'(key_valid), 32'h1);
    keys = 16'h0000;
    frames(3);
    keys[15] = 1'b1;
    frames(2);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_row_out", 32'(row_out), 32'h0000000E);
    check_eq("mid_rst_code", 32'(key_code), 32'h0);
    check_eq("mid_rst_valid", 32'(key_valid), 32'h0);
    check_eq("mid_rst_down", 32'(key_down), 32'h0);
    check_eq("mid_rst_ovf", 32'(overflow), 32'h0);
    rst = 1'b1;
    repeat (3 * FRAME - 1) @(negedge clk);
    check_eq("post_rst_not_yet", 32'(key_valid), 32'h0);
    @(negedge clk);
    check_eq("post_rst_valid", 32'(key_valid), 32'h1);
    check_eq("post_rst_code", 32'(key_code), 32'hF);
    repeat (FRAME - 1) @(negedge clk);
    ack_frame();
    keys = 16'h0000;
    frames(3);

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat: accept, +32 frames, then every 8 frames
    ev_base = ev_cnt;
    keys[7] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (key_valid) key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
      repeat (FRAME - 1) @(negedge clk);
    end
    check_eq("repeat_events", 32'(ev_cnt - ev_base), 32'h5);
    check_eq("repeat_code", 32'(key_code), 32'h7);
    keys = 16'h0000;
    frames(3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
